imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: IMEM_WORDS, default 128, instruction store depth in 17-bit words; power of two, 2..32768.
REQ-002 Port: clock  input  1  single clock; all state changes on posedge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: imemaddr  input  16  CPU fetch byte address (PC).
REQ-005 Port: imemrdata  output  17  instruction word to CPU.
REQ-006 Port: ld_start  input  1  begin or restart load session.
REQ-007 Port: ld_end  input  1  end load session and release CPU.
REQ-008 Port: ld_valid  input  1  ld_byte valid.
REQ-009 Port: ld_byte  input  8  load data byte.
REQ-010 Port: ld_ready  output  1  loader accepts a byte this cycle.
REQ-011 Port: cpu_reset  output  1  drives the CPU reset input.
REQ-012 Port: word_count  output  16  words written in the current session.
REQ-013 Port: ld_err  output  1  last session ended with a partial word.

Function
REQ-014 imemrdata SHALL be a combinational read of word index imemaddr[15:1]; imemaddr[0] is ignored.
REQ-015 imemrdata SHALL be 17'h0 when imemaddr[15:1] >= IMEM_WORDS.
REQ-016 A write and a read of the same index in the same cycle SHALL return the old word; the new word appears the cycle after the edge.
REQ-017 States: IDLE, LOAD, RELEASE, RUN.
REQ-018 cpu_reset SHALL be 1 in IDLE, LOAD and RELEASE, and 0 only in RUN.
REQ-019 ld_ready SHALL be 1 only in LOAD while word_count < IMEM_WORDS.
REQ-020 A byte is accepted on a posedge with ld_valid && ld_ready; ld_byte is ignored otherwise.
REQ-021 Word assembly: accepted byte 0 -> bits[7:0], byte 1 -> bits[15:8], byte 2 bit 0 -> bit 16 (byte 2 bits[7:1] ignored).
REQ-022 The third byte SHALL write the assembled word to index word_count at the same edge, increment word_count and reset the byte phase to 0.
REQ-023 ld_start in any state SHALL go to LOAD and clear word_count, the byte phase and ld_err.
REQ-024 ld_start SHALL take priority over ld_end in the same cycle.
REQ-025 ld_end in IDLE or LOAD SHALL go to RELEASE.
REQ-026 ld_end in RELEASE or RUN SHALL be ignored.
REQ-027 ld_end with an accepted byte in the same cycle: the byte is processed first; if it completes a word, the word is written and ld_err stays 0.
REQ-028 If a session ends with byte phase != 0 after REQ-027 is applied, the partial word SHALL be discarded and ld_err set to 1.
REQ-029 When a write makes word_count reach IMEM_WORDS, the state SHALL go to RELEASE at that same edge with no ld_end required.
REQ-030 RELEASE SHALL last exactly one cycle and then go to RUN, giving the CPU at least one synchronous reset edge.
REQ-031 word_count and ld_err SHALL hold their values through RELEASE and RUN until the next ld_start or reset.
REQ-032 Words not written in a session SHALL keep their prior contents; stored words are not cleared by reset.

Reset
REQ-033 reset SHALL take priority over all inputs.
REQ-034 On reset: state IDLE, cpu_reset=1, ld_ready=0, word_count=0, ld_err=0, byte phase=0.
REQ-035 Reset mid-LOAD SHALL abort the session; a partial word is discarded, but words already written are kept.

Verification
REQ-036 Load 2 words:
- Stimulus: ld_start, then bytes 34 12 01 78 56 00, then ld_end.
- Required: word_count=2, ld_err=0; cpu_reset=1 for the RELEASE cycle, then 0.
- Required: imemaddr=0 -> 17'h11234; imemaddr=2 -> 17'h05678.
REQ-037 Partial word:
- Stimulus: ld_start, bytes AA BB CC DD, ld_end.
- Required: word_count=1, ld_err=1, index 1 unchanged, state reaches RUN.
REQ-038 Simultaneous end:
- Stimulus: ld_end in the same cycle the third byte (FF) of word 0 is accepted.
- Required: word written, word_count=1, ld_err=0.
- Stimulus: ld_start and ld_end asserted together.
- Required: state LOAD, word_count=0.
REQ-039 Full store (IMEM_WORDS=4):
- Stimulus: stream 12 bytes with ld_valid held high.
- Required: RELEASE on the 12th byte's edge; ld_ready=0 afterwards; word_count=4.
- Required: imemaddr=16'h0008 -> 0.
REQ-040 Reset mid-session:
- Stimulus: reset after 4 bytes of a session.
- Required: IDLE, cpu_reset=1, word_count=0, word 0 retained.
- Stimulus: ld_end from IDLE.
- Required: RUN after 2 cycles with prior contents visible.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader/fetch bus for imem_loader: CPU fetch port plus the byte-load handshake.
// The bench/host side uses master, the loader uses slave.
interface imem_loader_if;
    logic [15:0] imemaddr;
    logic [16:0] imemrdata;
    logic        ld_start;
    logic        ld_end;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        cpu_reset;
    logic [15:0] word_count;
    logic        ld_err;

    modport master (
        output imemaddr, ld_start, ld_end, ld_valid, ld_byte,
        input  imemrdata, ld_ready, cpu_reset, word_count, ld_err
    );

    modport slave (
        input  imemaddr, ld_start, ld_end, ld_valid, ld_byte,
        output imemrdata, ld_ready, cpu_reset, word_count, ld_err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction store with a byte-serial loader; holds the CPU in reset while loading
// and releases it through a one-cycle RELEASE state.
module imem_loader #(
    parameter int unsigned IMEM_WORDS = 128
) (
    input  logic         clock,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int unsigned AW   = $clog2(IMEM_WORDS);
    localparam logic [15:0] FULL = 16'(IMEM_WORDS);

    typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

    state_t      state;
    logic [16:0] mem [IMEM_WORDS];
    logic [1:0]  phase;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic [15:0] word_count;
    logic        ld_err;
    logic        ld_ready;
    logic        cpu_reset;

    logic        accept;
    logic        word_done;
    logic        last_word;
    logic [16:0] wdata;
    logic [15:0] rindex;
    logic [16:0] rdata;
    logic        unused_addr_lsb;

    // ld_start restarts the session, so a byte offered alongside it is dropped.
    assign accept    = (state == LOAD) && ld_ready && bus.ld_valid && !bus.ld_start;
    assign word_done = accept && (phase == 2'd2) && !reset;
    assign last_word = (word_count + 16'd1) == FULL;
    assign wdata     = {bus.ld_byte[0], byte1, byte0};

    assign unused_addr_lsb = bus.imemaddr[0];

    always_ff @(posedge clock) begin
        if (word_done) begin
            mem[word_count[AW-1:0]] <= wdata;
        end
    end

    always_comb begin
        rindex = {1'b0, bus.imemaddr[15:1]};
        rdata  = '0;
        if (rindex < FULL) begin
            rdata = mem[rindex[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cpu_reset  <= 1'b1;
            ld_ready   <= 1'b0;
            word_count <= '0;
            ld_err     <= 1'b0;
            phase      <= '0;
        end else if (bus.ld_start) begin
            state      <= LOAD;
            cpu_reset  <= 1'b1;
            ld_ready   <= 1'b1;
            word_count <= '0;
            ld_err     <= 1'b0;
            phase      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_end) begin
                        state <= RELEASE;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        case (phase)
                            2'd0: begin
                                byte0 <= bus.ld_byte;
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                byte1 <= bus.ld_byte;
                                phase <= 2'd2;
                            end
                            default: begin
                                word_count <= word_count + 16'd1;
                                phase      <= '0;
                            end
                        endcase
                    end
                    // The byte of this cycle is folded in first; a session ending
                    // mid-word discards the partial and flags it.
                    if (word_done && last_word) begin
                        state    <= RELEASE;
                        ld_ready <= 1'b0;
                    end else if (bus.ld_end) begin
                        state    <= RELEASE;
                        ld_ready <= 1'b0;
                        phase    <= '0;
                        if (accept ? !word_done : (phase != 2'd0)) begin
                            ld_err <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    state     <= RUN;
                    cpu_reset <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.imemrdata  = rdata;
    assign bus.ld_ready   = ld_ready;
    assign bus.cpu_reset  = cpu_reset;
    assign bus.word_count = word_count;
    assign bus.ld_err     = ld_err;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a queue-based session model.
module tb_imem_loader;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    imem_loader_if bus();

    imem_loader #(.IMEM_WORDS(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    typedef enum {M_IDLE, M_LOAD, M_REL, M_RUN} mstage_t;
    mstage_t     m_stage = M_IDLE;
    int          m_wc = 0;
    bit          m_err = 1'b0;
    logic [7:0]  part[$];
    logic [16:0] m_mem [N];
    bit          m_valid [N];

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endfunction

    // Reference: a session is a list of accepted bytes; every third byte makes a word.
    always @(posedge clock) begin
        if (reset) begin
            m_stage = M_IDLE; m_wc = 0; m_err = 0; part.delete();
        end else if (bus.ld_start) begin
            m_stage = M_LOAD; m_wc = 0; m_err = 0; part.delete();
        end else begin
            case (m_stage)
                M_IDLE: if (bus.ld_end) m_stage = M_REL;
                M_LOAD: begin
                    if (bus.ld_valid && m_wc < N) begin
                        part.push_back(bus.ld_byte);
                        if (part.size() == 3) begin
                            m_mem[m_wc]   = {part[2][0], part[1], part[0]};
                            m_valid[m_wc] = 1'b1;
                            m_wc++;
                            part.delete();
                        end
                    end
                    if (m_wc == N) m_stage = M_REL;
                    else if (bus.ld_end) begin
                        m_stage = M_REL;
                        if (part.size() != 0) m_err = 1'b1;
                        part.delete();
                    end
                end
                M_REL: m_stage = M_RUN;
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            int idx;
            cmp("cpu_reset", 32'(bus.cpu_reset), 32'(m_stage != M_RUN));
            cmp("ld_ready", 32'(bus.ld_ready), 32'(m_stage == M_LOAD && m_wc < N));
            cmp("word_count", 32'(bus.word_count), 32'(m_wc));
            cmp("ld_err", 32'(bus.ld_err), 32'(m_err));
            idx = int'(bus.imemaddr >> 1);
            if (idx >= N) cmp("imemrdata_oob", 32'(bus.imemrdata), 32'h0);
            else if (m_valid[idx]) cmp("imemrdata", 32'(bus.imemrdata), 32'(m_mem[idx]));
        end
    end

    task automatic cyc(bit s, bit e, bit v, logic [7:0] b);
        bus.ld_start = s; bus.ld_end = e; bus.ld_valid = v; bus.ld_byte = b;
        @(posedge clock); #1;
        bus.ld_start = 0; bus.ld_end = 0; bus.ld_valid = 0;
    endtask

    task automatic rd(logic [15:0] a, logic [16:0] exp, string name);
        bus.imemaddr = a; #1;
        cmp(name, 32'(bus.imemrdata), 32'(exp));
    endtask

    task automatic send(logic [7:0] b);
        cyc(0, 0, 1, b);
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        bus.imemaddr = '0; bus.ld_start = 0; bus.ld_end = 0; bus.ld_valid = 0; bus.ld_byte = '0;
        reset = 1;
        cyc(0, 0, 0, 0);
        chk_en = 1;
        cyc(0, 0, 0, 0);
        cmp("rst_cpu_reset", 32'(bus.cpu_reset), 1);
        cmp("rst_ld_ready", 32'(bus.ld_ready), 0);
        cmp("rst_word_count", 32'(bus.word_count), 0);
        cmp("rst_ld_err", 32'(bus.ld_err), 0);
        reset = 0;

        // Two complete words
        cyc(1, 0, 0, 0);
        send(8'h34); send(8'h12); send(8'h01); send(8'h78); send(8'h56); send(8'h00);
        cyc(0, 1, 0, 0);
        cmp("two_release_cpu_reset", 32'(bus.cpu_reset), 1);
        cmp("two_word_count", 32'(bus.word_count), 2);
        cmp("two_ld_err", 32'(bus.ld_err), 0);
        cyc(0, 0, 0, 0);
        cmp("two_run_cpu_reset", 32'(bus.cpu_reset), 0);
        rd(16'h0000, 17'h11234, "two_word0");
        rd(16'h0002, 17'h05678, "two_word1");
        rd(16'h0003, 17'h05678, "two_word1_odd_addr");

        // Partial word
        cyc(1, 0, 0, 0);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        cyc(0, 1, 0, 0);
        cmp("part_word_count", 32'(bus.word_count), 1);
        cmp("part_ld_err", 32'(bus.ld_err), 1);
        rd(16'h0000, 17'h0BBAA, "part_word0");
        rd(16'h0002, 17'h05678, "part_word1_kept");
        cyc(0, 0, 0, 0);
        cmp("part_run_cpu_reset", 32'(bus.cpu_reset), 0);

        // End coincident with the completing byte, then start+end together
        cyc(1, 0, 0, 0);
        send(8'h11); send(8'h22);
        cyc(0, 1, 1, 8'hFF);
        cmp("sim_word_count", 32'(bus.word_count), 1);
        cmp("sim_ld_err", 32'(bus.ld_err), 0);
        rd(16'h0000, 17'h12211, "sim_word0");
        cyc(1, 1, 0, 0);
        cmp("startend_ld_ready", 32'(bus.ld_ready), 1);
        cmp("startend_word_count", 32'(bus.word_count), 0);
        cyc(0, 0, 0, 0);
        cmp("startend_still_load", 32'(bus.cpu_reset & bus.ld_ready), 1);

        // Fill the whole store with valid held high
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) send(8'(8'h10 + i));
        cmp("full_ld_ready", 32'(bus.ld_ready), 0);
        cmp("full_word_count", 32'(bus.word_count), 4);
        cmp("full_release_cpu_reset", 32'(bus.cpu_reset), 1);
        send(8'hEE);
        cmp("full_run_cpu_reset", 32'(bus.cpu_reset), 0);
        cmp("full_word_count_hold", 32'(bus.word_count), 4);
        rd(16'h0006, 17'h11A19, "full_word3");
        rd(16'h0008, 17'h00000, "full_oob");
        rd(16'hFFFF, 17'h00000, "full_oob_top");

        // Reset in the middle of a session
        cyc(1, 0, 0, 0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        reset = 1;
        cyc(0, 0, 0, 0);
        reset = 0;
        cmp("mid_rst_cpu_reset", 32'(bus.cpu_reset), 1);
        cmp("mid_rst_word_count", 32'(bus.word_count), 0);
        cmp("mid_rst_ld_ready", 32'(bus.ld_ready), 0);
        rd(16'h0000, 17'h10201, "mid_rst_word0");
        cyc(0, 1, 0, 0);
        cmp("idle_end_release", 32'(bus.cpu_reset), 1);
        cyc(0, 0, 0, 0);
        cmp("idle_end_run", 32'(bus.cpu_reset), 0);
        rd(16'h0002, 17'h11413, "idle_end_word1");

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.imemaddr = 16'($urandom_range(0, 4 * N - 1));
            reset = ($urandom_range(0, 199) == 0);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 1) == 1, 8'($urandom));
        end
        reset = 0;
        cyc(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
